// File: rtl/tabla_verdad_seq_pkg.sv
// Shared definitions for the truth-table sequencer: operation codes and FSM states.
// No logic; no latency; no backpressure.
package tabla_verdad_seq_pkg;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_NAND = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/eval_compuertas.sv
// Combinational evaluator: reduction of vec by op, plus strict majority of ones.
// Latency 0 (pure logic); no backpressure.
module eval_compuertas
    import tabla_verdad_seq_pkg::*;
#(
    parameter int N = 3
) (
    input  logic [N-1:0] vec,
    input  logic [1:0]   op,
    output logic         s1,
    output logic         s2
);

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] HALF = CW'(N / 2);

    logic [CW-1:0] cnt;

    always_comb begin
        cnt = '0;
        for (int i = 0; i < N; i++) begin
            cnt = cnt + CW'(vec[i]);
        end
        s2 = (cnt > HALF);
        s1 = 1'b0;
        case (op)
            OP_AND:  s1 = &vec;
            OP_OR:   s1 = |vec;
            OP_XOR:  s1 = ^vec;
            default: s1 = ~&vec;
        endcase
    end

endmodule

// File: rtl/tabla_verdad_seq.sv
// Truth-table sequencer: manual vector pass-through or automatic 0..2^N-1 sweep with S1 tally.
// Latency 1 cycle from IN/OP to vec_out/S1/S2; sweep runs 2^N*HOLD+1 cycles before done.
// No backpressure: start is ignored while busy, abort cancels a running sweep.
module tabla_verdad_seq
    import tabla_verdad_seq_pkg::*;
#(
    parameter int N    = 3,
    parameter int HOLD = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] IN,
    input  logic [1:0]   OP,
    input  logic         start,
    input  logic         abort,
    output logic [N-1:0] vec_out,
    output logic         S1,
    output logic         S2,
    output logic         busy,
    output logic         done,
    output logic [N:0]   ones_cnt
);

    localparam logic [7:0]   HOLD_LAST = 8'(HOLD - 1);
    localparam logic [7:0]   HOLD_END  = 8'(HOLD);
    localparam logic [N-1:0] VEC_LAST  = {N{1'b1}};
    localparam logic [N-1:0] VEC_ONE   = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N:0]   CNT_ONE   = {{N{1'b0}}, 1'b1};

    state_t       state_q, state_d;
    logic [N-1:0] vec_q, vec_d;
    logic [7:0]   hold_q, hold_d;
    logic [1:0]   op_q, op_d;
    logic [N:0]   ones_q, ones_d;
    logic         s1_q, s1_d;
    logic         s2_q, s2_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic [1:0]   op_eval;

    // S1/S2 are evaluated on the next vector so they register alongside vec_out.
    eval_compuertas #(.N(N)) u_eval (
        .vec (vec_d),
        .op  (op_eval),
        .s1  (s1_d),
        .s2  (s2_d)
    );

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        hold_d  = hold_q;
        op_d    = op_q;
        ones_d  = ones_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        op_eval = op_q;
        case (state_q)
            ST_IDLE: begin
                vec_d   = IN;
                op_eval = OP;
                busy_d  = 1'b0;
                if (start) begin
                    state_d = ST_SWEEP;
                    vec_d   = '0;
                    hold_d  = '0;
                    op_d    = OP;
                    ones_d  = '0;
                    busy_d  = 1'b1;
                end
            end
            ST_SWEEP: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    hold_d  = '0;
                    busy_d  = 1'b0;
                end else begin
                    if (hold_q == HOLD_LAST && s1_q) begin
                        ones_d = ones_q + CNT_ONE;
                    end
                    // The last vector gets one extra cycle so its tally is visible before done.
                    if (vec_q != VEC_LAST && hold_q == HOLD_LAST) begin
                        vec_d  = vec_q + VEC_ONE;
                        hold_d = '0;
                    end else if (vec_q == VEC_LAST && hold_q == HOLD_END) begin
                        state_d = ST_DONE;
                        hold_d  = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        hold_d = hold_q + 8'd1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            vec_q   <= '0;
            hold_q  <= '0;
            op_q    <= '0;
            ones_q  <= '0;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            hold_q  <= hold_d;
            op_q    <= op_d;
            ones_q  <= ones_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign vec_out  = vec_q;
    assign S1       = s1_q;
    assign S2       = s2_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign ones_cnt = ones_q;

endmodule

// File: tb/tb_tabla_verdad_seq.sv
// Directed bench: N=3/HOLD=4 instance for manual, sweep, abort and reset; N=4/HOLD=1 for the short sweep.
module tb_tabla_verdad_seq;

    logic       clk;
    logic       rst_n;
    logic [2:0] in_a;
    logic [1:0] op_a;
    logic       start_a, abort_a;
    logic [2:0] vec_a;
    logic       s1_a, s2_a, busy_a, done_a;
    logic [3:0] ones_a;

    logic [3:0] in_b;
    logic [1:0] op_b;
    logic       start_b, abort_b;
    logic [3:0] vec_b;
    logic       s1_b, s2_b, busy_b, done_b;
    logic [4:0] ones_b;

    int checks;
    int failures;

    tabla_verdad_seq #(.N(3), .HOLD(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .IN(in_a), .OP(op_a), .start(start_a), .abort(abort_a),
        .vec_out(vec_a), .S1(s1_a), .S2(s2_a), .busy(busy_a), .done(done_a), .ones_cnt(ones_a)
    );

    tabla_verdad_seq #(.N(4), .HOLD(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .IN(in_b), .OP(op_b), .start(start_b), .abort(abort_b),
        .vec_out(vec_b), .S1(s1_b), .S2(s2_b), .busy(busy_b), .done(done_b), .ones_cnt(ones_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset;
        rst_n = 1'b0;
        in_a = 3'b101; op_a = 2'b11; start_a = 1'b0; abort_a = 1'b0;
        in_b = 4'b1111; op_b = 2'b11; start_b = 1'b0; abort_b = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({vec_a, s1_a, s2_a, busy_a, done_a, ones_a} !== 11'd0) begin
            failures++;
            $display("FAIL reset_a: got %b required 0", {vec_a, s1_a, s2_a, busy_a, done_a, ones_a});
        end
        checks++;
        if ({vec_b, s1_b, s2_b, busy_b, done_b, ones_b} !== 13'd0) begin
            failures++;
            $display("FAIL reset_b: got %b required 0", {vec_b, s1_b, s2_b, busy_b, done_b, ones_b});
        end
        in_a = 3'b000; op_a = 2'b00; in_b = 4'b0000; op_b = 2'b00;
        rst_n = 1'b1;
    endtask

    task automatic test_manual;
        logic [2:0] in_v [4];
        logic [1:0] op_v [4];
        logic [4:0] exp_v [4];
        in_v[0] = 3'b011; op_v[0] = 2'b01; exp_v[0] = {3'b011, 1'b1, 1'b1};
        in_v[1] = 3'b001; op_v[1] = 2'b00; exp_v[1] = {3'b001, 1'b0, 1'b0};
        in_v[2] = 3'b110; op_v[2] = 2'b10; exp_v[2] = {3'b110, 1'b0, 1'b1};
        in_v[3] = 3'b000; op_v[3] = 2'b11; exp_v[3] = {3'b000, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_a = in_v[i]; op_a = op_v[i];
            @(negedge clk);
            checks++;
            if ({vec_a, s1_a, s2_a} !== exp_v[i] || busy_a !== 1'b0) begin
                failures++;
                $display("FAIL manual_%0d: vec/S1/S2=%b busy=%b required %b busy=0",
                         i, {vec_a, s1_a, s2_a}, busy_a, exp_v[i]);
            end
        end
    endtask

    task automatic test_sweep_and;
        int done_at;
        int vec_err;
        int exp_v;
        logic [3:0] ones_at;
        logic [2:0] vec_at;
        logic busy_at;
        @(negedge clk);
        op_a = 2'b00; in_a = 3'b111; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        checks++;
        if (vec_a !== 3'd0 || busy_a !== 1'b1 || ones_a !== 4'd0) begin
            failures++;
            $display("FAIL and_start: vec=%0d busy=%b ones=%0d required 0 1 0", vec_a, busy_a, ones_a);
        end
        done_at = 0; vec_err = 0; ones_at = '0; vec_at = '0; busy_at = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (done_a === 1'b1) begin
                done_at = i; ones_at = ones_a; vec_at = vec_a; busy_at = busy_a;
                break;
            end
            exp_v = (i / 4 > 7) ? 7 : i / 4;
            if (vec_a !== 3'(exp_v)) vec_err++;
        end
        checks++;
        if (done_at != 33) begin
            failures++;
            $display("FAIL and_done_time: done after edge k+%0d required k+33", done_at);
        end
        checks++;
        if (vec_err != 0) begin
            failures++;
            $display("FAIL and_vec_seq: %0d wrong vec_out cycles required 0", vec_err);
        end
        checks++;
        if (ones_at !== 4'd1 || vec_at !== 3'd7 || busy_at !== 1'b0) begin
            failures++;
            $display("FAIL and_done_state: ones=%0d vec=%0d busy=%b required 1 7 0", ones_at, vec_at, busy_at);
        end
        @(negedge clk);
        checks++;
        if (done_a !== 1'b0 || ones_a !== 4'd1 || vec_a !== 3'b111) begin
            failures++;
            $display("FAIL and_after_done: done=%b ones=%0d vec=%b required 0 1 111", done_a, ones_a, vec_a);
        end
    endtask

    task automatic test_sweep_xor;
        logic [7:0] par_t;
        logic [7:0] maj_t;
        int done_at;
        int s_err;
        int v;
        logic [3:0] ones_at;
        par_t = 8'b1001_0110;
        maj_t = 8'b1110_1000;
        @(negedge clk);
        op_a = 2'b10; in_a = 3'b000; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        op_a = 2'b00;
        done_at = 0; s_err = 0; ones_at = '0;
        if (s1_a !== par_t[0] || s2_a !== maj_t[0]) s_err++;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            start_a = (i == 10);
            if (done_a === 1'b1) begin
                done_at = i; ones_at = ones_a;
                break;
            end
            v = (i / 4 > 7) ? 7 : i / 4;
            if (s1_a !== par_t[v] || s2_a !== maj_t[v]) s_err++;
        end
        start_a = 1'b0;
        checks++;
        if (done_at != 33) begin
            failures++;
            $display("FAIL xor_done_time: done after edge k+%0d required k+33", done_at);
        end
        checks++;
        if (ones_at !== 4'd4) begin
            failures++;
            $display("FAIL xor_ones: ones=%0d required 4", ones_at);
        end
        checks++;
        if (s_err != 0) begin
            failures++;
            $display("FAIL xor_s1_s2: %0d cycles with wrong S1/S2 required 0", s_err);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (ones_a !== 4'd4 || busy_a !== 1'b0) begin
            failures++;
            $display("FAIL xor_hold_ones: ones=%0d busy=%b required 4 0", ones_a, busy_a);
        end
    endtask

    task automatic test_abort;
        int done_seen;
        @(negedge clk);
        op_a = 2'b00; in_a = 3'b010; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        checks++;
        if (ones_a !== 4'd0 || busy_a !== 1'b1) begin
            failures++;
            $display("FAIL abort_start_clears: ones=%0d busy=%b required 0 1", ones_a, busy_a);
        end
        for (int i = 1; i <= 21; i++) @(negedge clk);
        checks++;
        if (vec_a !== 3'd5) begin
            failures++;
            $display("FAIL abort_at_vec: vec=%0d required 5", vec_a);
        end
        abort_a = 1'b1;
        @(negedge clk);
        abort_a = 1'b0;
        checks++;
        if (busy_a !== 1'b0 || done_a !== 1'b0) begin
            failures++;
            $display("FAIL abort_busy: busy=%b done=%b required 0 0", busy_a, done_a);
        end
        done_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done_a === 1'b1 || busy_a === 1'b1) done_seen++;
        end
        checks++;
        if (done_seen != 0 || ones_a !== 4'd0 || vec_a !== 3'b010) begin
            failures++;
            $display("FAIL abort_after: busy/done cycles=%0d ones=%0d vec=%b required 0 0 010",
                     done_seen, ones_a, vec_a);
        end
        in_a = 3'b101; abort_a = 1'b1;
        @(negedge clk);
        checks++;
        if (vec_a !== 3'b101 || busy_a !== 1'b0) begin
            failures++;
            $display("FAIL abort_idle: vec=%b busy=%b required 101 0", vec_a, busy_a);
        end
        op_a = 2'b10; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        checks++;
        if (busy_a !== 1'b1 || vec_a !== 3'd0) begin
            failures++;
            $display("FAIL start_beats_abort: busy=%b vec=%0d required 1 0", busy_a, vec_a);
        end
        @(negedge clk);
        abort_a = 1'b0;
        checks++;
        if (busy_a !== 1'b0 || done_a !== 1'b0) begin
            failures++;
            $display("FAIL abort_next_cycle: busy=%b done=%b required 0 0", busy_a, done_a);
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        op_a = 2'b11; in_a = 3'b000; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        for (int i = 1; i <= 25; i++) @(negedge clk);
        checks++;
        if (vec_a !== 3'd6 || s1_a !== 1'b1 || s2_a !== 1'b1 || busy_a !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_pre: vec=%0d S1=%b S2=%b busy=%b required 6 1 1 1", vec_a, s1_a, s2_a, busy_a);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({vec_a, s1_a, s2_a, busy_a, done_a, ones_a} !== 11'd0) begin
            failures++;
            $display("FAIL reset_mid_async: got %b required 0", {vec_a, s1_a, s2_a, busy_a, done_a, ones_a});
        end
        @(negedge clk);
        in_a = 3'b111; op_a = 2'b00;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({vec_a, s1_a, s2_a} !== 5'b111_1_1 || busy_a !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: vec/S1/S2=%b busy=%b required 11111 0", {vec_a, s1_a, s2_a}, busy_a);
        end
    endtask

    task automatic test_n4_nand;
        int done_at;
        logic [4:0] ones_at;
        logic [3:0] vec_at;
        @(negedge clk);
        op_b = 2'b11; start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        done_at = 0; ones_at = '0; vec_at = '0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (done_b === 1'b1) begin
                done_at = i; ones_at = ones_b; vec_at = vec_b;
                break;
            end
        end
        checks++;
        if (done_at != 17) begin
            failures++;
            $display("FAIL n4_done_time: done after edge k+%0d required k+17", done_at);
        end
        checks++;
        if (ones_at !== 5'd15 || vec_at !== 4'hF) begin
            failures++;
            $display("FAIL n4_ones: ones=%0d vec=%0d required 15 15", ones_at, vec_at);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_manual();
        test_sweep_and();
        test_sweep_xor();
        test_abort();
        test_reset_mid();
        test_n4_nand();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tabla_verdad_seq.md
TABLA_VERDAD_SEQ -- requirements
Module: tabla_verdad_seq

Interface
REQ-001 Parameter N, default 3: input vector width; legal range 2..8.
REQ-002 Parameter HOLD, default 4: clock cycles each vector is held during a sweep; legal range 1..255.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 IN  input  N  manual input vector, used in IDLE.
REQ-006 OP  input  2  operation select: 00 AND, 01 OR, 10 XOR, 11 NAND, each reducing all N bits.
REQ-007 start  input  1  one-cycle request to begin an automatic truth-table sweep.
REQ-008 abort  input  1  synchronous sweep cancel.
REQ-009 vec_out  output  N  vector currently applied.
REQ-010 S1  output  1  result of OP on vec_out.
REQ-011 S2  output  1  majority of vec_out: 1 when the count of ones in vec_out is greater than N/2 (strict; for even N, exactly N/2 ones gives 0).
REQ-012 busy  output  1  high while a sweep is running.
REQ-013 done  output  1  one-cycle pulse when a sweep completes.
REQ-014 ones_cnt  output  N+1  number of swept vectors for which S1=1.

Function
REQ-015 The block SHALL implement states IDLE, SWEEP and DONE.
REQ-016 In IDLE, vec_out SHALL register IN every cycle, giving 1-cycle latency.
REQ-017 S1 and S2 SHALL be registered and computed from the same next-vector value as vec_out, so all three are mutually consistent in every cycle.
REQ-018 In IDLE, OP SHALL be used live.
REQ-019 At the edge where start is sampled high in IDLE:
- OP SHALL be latched and held for the whole sweep.
- ones_cnt SHALL be cleared.
- The state SHALL move to SWEEP.
- vec_out SHALL become 0 and busy SHALL become 1 after that edge.
REQ-020 In SWEEP, each vector value SHALL be held for exactly HOLD cycles, then vec_out SHALL increment by 1.
REQ-021 Vectors SHALL be applied in the order 0 to 2^N-1.
REQ-022 On the last hold cycle of each vector, ones_cnt SHALL increment by 1 if S1=1; the new value is visible the following cycle.
REQ-023 After the last hold cycle of vector 2^N-1:
- The state SHALL move to DONE for one cycle, with done=1 and busy=0.
- In that DONE cycle, ones_cnt SHALL hold its final value.
- vec_out SHALL hold 2^N-1.
- The state SHALL then move to IDLE.
REQ-024 vec_out SHALL never wrap from 2^N-1 back to 0 inside a sweep.
REQ-025 ones_cnt SHALL reach at most 2^N, which needs N+1 bits; it SHALL never overflow.
REQ-026 ones_cnt SHALL hold its value after DONE and after abort, until the next accepted start or reset.
REQ-027 start SHALL be ignored while in SWEEP or DONE.
REQ-028 abort sampled high in SWEEP SHALL return the state to IDLE at that edge:
- busy becomes 0.
- No done pulse is produced.
- ones_cnt keeps the partial count.
REQ-029 abort SHALL have no effect in IDLE or DONE.
REQ-030 If start and abort are both high in IDLE, start SHALL win; abort SHALL be honoured from the next cycle on.

Reset
REQ-031 rst_n low SHALL, asynchronously and at any time (including mid-sweep), force:
- state IDLE;
- vec_out, S1, S2, busy, done = 0;
- ones_cnt = 0;
- hold counter and latched OP = 0.
REQ-032 After rst_n deasserts, the first rising edge SHALL behave as normal IDLE operation.

Structure
REQ-033 A shared package SHALL hold:
- the OP encoding constants (AND, OR, XOR, NAND);
- the state enumeration (IDLE, SWEEP, DONE).
REQ-034 The combinational evaluator (OP reduction plus majority) SHALL be a sub-module named eval_compuertas, parameterised by N.
REQ-035 The FSM, hold counter, vector counter and ones counter SHALL live in tabla_verdad_seq.

Verification
REQ-036 Manual mode, N=3: IN=3'b011, OP=01 -> one cycle later vec_out=011, S1=1, S2=1; then IN=3'b001, OP=00 -> vec_out=001, S1=0, S2=0.
REQ-037 Sweep, N=3, HOLD=4, OP=00, start sampled at edge k -> vec_out=0 after edge k; done=1 only after edge k+33; ones_cnt=1.
REQ-038 Sweep, N=3, HOLD=4, OP=10 -> ones_cnt=4 at done. During the same sweep, S2=1 only for vectors 011, 101, 110 and 111.
REQ-039 Sweep, N=3, OP=00: abort while vec_out=5 -> busy=0 next cycle, no done pulse; ones_cnt=0. A start pulse during the sweep -> ignored, and the sweep timing is unchanged.
REQ-040 Reset while vec_out=6 mid-sweep -> all outputs 0 immediately, without waiting for a clock edge.
REQ-041 N=4, HOLD=1, OP=11 -> done after 17 cycles, ones_cnt=15.
